tag_pio_edge_in: RTL and testbench

- Avalon-MM slave input PIO that samples external pushbuttons and switches and makes them readable by the Nios II.
- Synchronizes `in_port`, detects edges, latches them in a sticky edge-capture register, and raises a level IRQ through a per-bit mask.
- Input-side counterpart of the system's output PIOs (HEX/LED drivers); sits on the same Avalon bus and same clock domain.

---
 rtl/tag_pio_pkg.sv | 15 +
 rtl/tag_pio_debounce_bit.sv | 44 ++++
 rtl/tag_pio_edge_in.sv | 111 +++++++++++
 tb/tb_tag_pio_edge_in.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/tag_pio_pkg.sv
// Shared constants for the tag_pio input PIO: register addresses and edge-type codes.
package tag_pio_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA    = 2'd0,
        ADDR_RSVD    = 2'd1,
        ADDR_IRQMASK = 2'd2,
        ADDR_EDGECAP = 2'd3
    } pio_addr_e;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/tag_pio_debounce_bit.sv
// Single-bit debouncer: the output follows the synced input only after it has
// differed from the current stable value for DEBOUNCE_CYCLES consecutive cycles.
module tag_pio_debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic        IDLE            = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;

    // Flip on the cycle the count sits at DEBOUNCE_CYCLES-1, giving exactly
    // DEBOUNCE_CYCLES cycles of added latency.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (din != stable_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = din;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            stable_q <= IDLE;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign dout = stable_q;

endmodule

// File: rtl/tag_pio_edge_in.sv
// Avalon-MM input PIO: synchronizer, edge capture (W1C) and masked level IRQ.
// Define TAG_PIO_DEBOUNCE_EN to insert a per-bit debouncer after the synchronizer.
module tag_pio_edge_in
    import tag_pio_pkg::*;
#(
    parameter int unsigned       WIDTH           = 4,
    parameter int unsigned       EDGE_TYPE       = EDGE_FALL,
    parameter logic [WIDTH-1:0]  IDLE_LEVEL      = 4'hF,
    parameter int unsigned       SYNC_STAGES     = 2,
    parameter int unsigned       DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
        $error("tag_pio_edge_in: illegal parameter combination");
    end

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] level_dly_q, level_dly_d;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic             wr_en;
    logic             unused_wdata;

    always_comb begin
        sync_d[0] = in_port;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

`ifdef TAG_PIO_DEBOUNCE_EN
    for (genvar g = 0; g < WIDTH; g++) begin : g_debounce
        tag_pio_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .IDLE           (IDLE_LEVEL[g])
        ) u_debounce (
            .clk    (clk),
            .reset_n(reset_n),
            .din    (sync_q[SYNC_STAGES-1][g]),
            .dout   (level[g])
        );
    end
`else
    assign level = sync_q[SYNC_STAGES-1];
`endif

    assign level_dly_d = level;

    always_comb begin
        case (EDGE_TYPE)
            EDGE_RISE: edge_pulse = level & ~level_dly_q;
            EDGE_FALL: edge_pulse = ~level & level_dly_q;
            default:   edge_pulse = level ^ level_dly_q;
        endcase
    end

    assign wr_en        = chipselect && !write_n;
    assign unused_wdata = ^writedata;

    // A new edge is ORed in after the clear so it survives a simultaneous W1C.
    always_comb begin
        edgecap_d = edgecap_q;
        irqmask_d = irqmask_q;
        if (wr_en && address == ADDR_EDGECAP) begin
            edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
        end
        if (wr_en && address == ADDR_IRQMASK) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        edgecap_d = edgecap_d | edge_pulse;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= {SYNC_STAGES{IDLE_LEVEL}};
            level_dly_q <= IDLE_LEVEL;
            edgecap_q   <= '0;
            irqmask_q   <= '0;
        end else begin
            sync_q      <= sync_d;
            level_dly_q <= level_dly_d;
            edgecap_q   <= edgecap_d;
            irqmask_q   <= irqmask_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (pio_addr_e'(address))
            ADDR_DATA:    readdata[WIDTH-1:0] = level;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_q;
            default:      readdata = '0;
        endcase
    end

    assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_tag_pio_edge_in.sv
// Scoreboard bench for tag_pio_edge_in; define TAG_PIO_DEBOUNCE_EN to run the debounce sequence.
module tb_tag_pio_edge_in;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  in_port;
    logic        irq;

    tag_pio_edge_in #(
        .WIDTH          (4),
        .EDGE_TYPE      (1),
        .IDLE_LEVEL     (4'hF),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        irq;
    } exp_t;

    exp_t exp_q[$];
    event rd_ev;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Monitor: each read strobe presents readdata/irq; compare against the oldest expectation.
    always @(rd_ev) begin
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: read observed with no expectation queued");
        end else begin
            e = exp_q.pop_front();
            n_checks++;
            if (readdata !== e.data) begin
                n_fail++;
                $display("FAIL %s: readdata got 0x%08h expected 0x%08h", e.name, readdata, e.data);
            end
            n_checks++;
            if (irq !== e.irq) begin
                n_fail++;
                $display("FAIL %s_irq: irq got %b expected %b", e.name, irq, e.irq);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input logic [1:0] a, input logic [31:0] d, input logic i, input string nm);
        exp_t e;
        address = a;
        #1;
        e.name = nm;
        e.data = d;
        e.irq  = i;
        exp_q.push_back(e);
        -> rd_ev;
        #1;
    endtask

    task automatic write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        check(2'd0, 32'h0000_000F, 1'b0, "rst_data");
        check(2'd3, 32'h0, 1'b0, "rst_edgecap");
        check(2'd2, 32'h0, 1'b0, "rst_irqmask");
        repeat (10) tick();
        check(2'd3, 32'h0, 1'b0, "idle_no_edge");

`ifndef TAG_PIO_DEBOUNCE_EN
        write(2'd2, 32'h5);
        in_port = 4'hE;
        tick();
        check(2'd3, 32'h0, 1'b0, "lat_edge1");
        tick();
        check(2'd3, 32'h0, 1'b0, "lat_edge2");
        tick();
        check(2'd3, 32'h1, 1'b1, "lat_edge3");
        check(2'd0, 32'hE, 1'b1, "data_e");

        in_port = 4'hF;
        repeat (4) tick();
        check(2'd3, 32'h1, 1'b1, "rise_ignored");

        write(2'd3, 32'h1);
        check(2'd3, 32'h0, 1'b0, "w1c_clear");

        in_port = 4'h7;
        repeat (3) tick();
        check(2'd3, 32'h8, 1'b0, "masked_bit3");
        write(2'd2, 32'hF);
        check(2'd2, 32'hF, 1'b1, "unmask_irq");

        write(2'd3, 32'h8);
        check(2'd3, 32'h0, 1'b0, "clear_bit3");
        in_port = 4'h6;
        tick();
        tick();
        write(2'd3, 32'h1);
        check(2'd3, 32'h1, 1'b1, "set_wins");

        write(2'd0, 32'h0);
        check(2'd0, 32'h6, 1'b1, "data_ro");
        write(2'd1, 32'hFFFF_FFFF);
        check(2'd1, 32'h0, 1'b1, "rsvd_zero");
        check(2'd0, 32'h6, 1'b1, "data_after_rsvd");

        write(2'd3, 32'h1);
        check(2'd3, 32'h0, 1'b0, "clear_bit0");
        in_port = 4'hF;
        repeat (4) tick();
        check(2'd3, 32'h0, 1'b0, "rise_no_cap");
        in_port = 4'h5;
        repeat (3) tick();
        check(2'd3, 32'hA, 1'b1, "cap_a");
`else
        in_port = 4'hD;
        repeat (5) tick();
        in_port = 4'hF;
        repeat (20) tick();
        check(2'd0, 32'hF, 1'b0, "glitch_data");
        check(2'd3, 32'h0, 1'b0, "glitch_cap");

        in_port = 4'hD;
        repeat (9) tick();
        check(2'd0, 32'hF, 1'b0, "deb_before");
        tick();
        check(2'd0, 32'hD, 1'b0, "deb_after");
        check(2'd3, 32'h0, 1'b0, "deb_cap_wait");
        tick();
        check(2'd3, 32'h2, 1'b0, "deb_cap");
        write(2'd2, 32'hF);
        check(2'd2, 32'hF, 1'b1, "deb_unmask");
        repeat (10) tick();
        in_port = 4'h5;
`endif

        reset_n = 1'b0;
        check(2'd3, 32'h0, 1'b0, "mid_rst_edgecap");
        check(2'd2, 32'h0, 1'b0, "mid_rst_irqmask");
        check(2'd0, 32'hF, 1'b0, "mid_rst_data");
        in_port = 4'hF;
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check(2'd3, 32'h0, 1'b0, "post_rst_edgecap");

        #20;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
